// File: rtl/ep2_cmd_decoder.sv
// ep2_cmd_decoder: executes (addr,data) byte pairs from the EP2 OUT buffer as local register
// writes or opencores_i2c wishbone cycles, returning wishbone read data through the EP2 IN buffer.
module ep2_cmd_decoder #(
   parameter int RD_LAT     = 4,
   parameter int WB_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        buf_out_hasdata,
   input  logic [9:0]  buf_out_len,
   output logic [8:0]  buf_out_addr,
   input  logic [7:0]  buf_out_q,
   output logic        buf_out_arm,
   input  logic        buf_out_arm_ack,
   output logic [8:0]  usb_in_addr,
   output logic [7:0]  usb_in_data,
   output logic        usb_in_wren,
   input  logic        usb_in_ready,
   output logic        usb_in_commit,
   output logic [9:0]  usb_in_commit_len,
   input  logic        usb_in_commit_ack,
   output logic [2:0]  wb_adr_o,
   output logic [7:0]  wb_dat_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   input  logic [7:0]  wb_dat_i,
   input  logic        wb_ack_i,
   output logic [7:0]  reset_ctrl,
   output logic [1:0]  insel,
   output logic [10:0] isoc_commit_len,
   output logic [7:0]  err_cnt
);
   localparam int TW = $clog2(WB_TIMEOUT + 1);
   localparam logic [3:0] RD_LAST = 4'(RD_LAT);
   localparam logic [TW-1:0] TMO_LAST = TW'(WB_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH_A, S_FETCH_D, S_EXEC, S_WB_WAIT, S_NEXT, S_ARM, S_COMMIT
   } state_t;

   state_t        state_q;
   logic [8:0]    ptr_q, rem_q, rdcnt_q, buf_out_addr_q, usb_in_addr_q;
   logic [3:0]    cnt_q;
   logic [TW-1:0] tmo_q;
   logic [7:0]    addr_byte_q, data_byte_q, usb_in_data_q, wb_dat_q, reset_ctrl_q, err_q;
   logic [2:0]    sync_q, wb_adr_q;
   logic [1:0]    insel_q;
   logic [10:0]   isoc_q;
   logic [9:0]    commit_len_q;
   logic          buf_out_arm_q, usb_in_wren_q, usb_in_commit_q, wb_we_q, wb_stb_q;
   logic          acked, unused_len;
   logic [7:0]    err_sat;

   // the arm acknowledge comes from the USB clock domain; only its synced falling edge counts
   assign acked      = sync_q[2] & ~sync_q[1];
   assign err_sat    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
   assign unused_len = buf_out_len[0];

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q        <= S_IDLE;
         ptr_q          <= '0;
         rem_q          <= '0;
         rdcnt_q        <= '0;
         cnt_q          <= '0;
         tmo_q          <= '0;
         addr_byte_q    <= '0;
         data_byte_q    <= '0;
         sync_q         <= '0;
         buf_out_addr_q <= '0;
         buf_out_arm_q  <= 1'b0;
         usb_in_addr_q  <= '0;
         usb_in_data_q  <= '0;
         usb_in_wren_q  <= 1'b0;
         usb_in_commit_q <= 1'b0;
         commit_len_q   <= '0;
         wb_adr_q       <= '0;
         wb_dat_q       <= '0;
         wb_we_q        <= 1'b0;
         wb_stb_q       <= 1'b0;
         reset_ctrl_q   <= 8'hF3;
         insel_q        <= '0;
         isoc_q         <= 11'd512;
         err_q          <= '0;
      end else begin
         sync_q        <= {sync_q[1:0], buf_out_arm_ack};
         usb_in_wren_q <= 1'b0;
         case (state_q)
            S_IDLE:
               if (buf_out_hasdata && usb_in_ready) begin
                  rem_q          <= buf_out_len[9:1];
                  ptr_q          <= '0;
                  rdcnt_q        <= '0;
                  buf_out_addr_q <= '0;
                  cnt_q          <= '0;
                  if (buf_out_len[9:1] == 9'd0) begin
                     buf_out_arm_q <= 1'b1;
                     state_q       <= S_ARM;
                  end else
                     state_q <= S_FETCH_A;
               end
            S_FETCH_A:
               if (cnt_q == RD_LAST) begin
                  addr_byte_q    <= buf_out_q;
                  buf_out_addr_q <= ptr_q + 9'd1;
                  cnt_q          <= '0;
                  state_q        <= S_FETCH_D;
               end else
                  cnt_q <= cnt_q + 4'd1;
            S_FETCH_D:
               if (cnt_q == RD_LAST) begin
                  data_byte_q <= buf_out_q;
                  state_q     <= S_EXEC;
               end else
                  cnt_q <= cnt_q + 4'd1;
            S_EXEC: begin
               tmo_q   <= '0;
               state_q <= S_NEXT;
               case (addr_byte_q)
                  8'd0, 8'd1, 8'd2, 8'd3, 8'd4: begin
                     wb_adr_q <= addr_byte_q[2:0];
                     wb_dat_q <= data_byte_q;
                     wb_we_q  <= 1'b1;
                     wb_stb_q <= 1'b1;
                     state_q  <= S_WB_WAIT;
                  end
                  8'd5: begin
                     wb_adr_q <= data_byte_q[2:0];
                     wb_we_q  <= 1'b0;
                     wb_stb_q <= 1'b1;
                     state_q  <= S_WB_WAIT;
                  end
                  8'd6: reset_ctrl_q <= data_byte_q;
                  8'd7: insel_q <= data_byte_q[1:0];
                  8'd8: isoc_q[10:8] <= data_byte_q[2:0];
                  8'd9: isoc_q[7:0] <= data_byte_q;
                  default: err_q <= err_sat;
               endcase
            end
            S_WB_WAIT:
               if (wb_ack_i) begin
                  wb_stb_q <= 1'b0;
                  wb_we_q  <= 1'b0;
                  state_q  <= S_NEXT;
                  if (!wb_we_q) begin
                     usb_in_data_q <= wb_dat_i;
                     usb_in_addr_q <= rdcnt_q;
                     usb_in_wren_q <= 1'b1;
                     rdcnt_q       <= rdcnt_q + 9'd1;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  wb_stb_q <= 1'b0;
                  wb_we_q  <= 1'b0;
                  err_q    <= err_sat;
                  state_q  <= S_NEXT;
               end else
                  tmo_q <= tmo_q + 1'b1;
            S_NEXT:
               if (rem_q == 9'd1) begin
                  buf_out_arm_q <= 1'b1;
                  state_q       <= S_ARM;
               end else begin
                  rem_q          <= rem_q - 9'd1;
                  ptr_q          <= ptr_q + 9'd2;
                  buf_out_addr_q <= ptr_q + 9'd2;
                  cnt_q          <= '0;
                  state_q        <= S_FETCH_A;
               end
            S_ARM:
               if (acked) begin
                  buf_out_arm_q <= 1'b0;
                  if (rdcnt_q != 9'd0) begin
                     usb_in_commit_q <= 1'b1;
                     commit_len_q    <= {1'b0, rdcnt_q};
                     state_q         <= S_COMMIT;
                  end else
                     state_q <= S_IDLE;
               end
            S_COMMIT:
               if (usb_in_commit_ack) begin
                  usb_in_commit_q <= 1'b0;
                  state_q         <= S_IDLE;
               end
            default: state_q <= S_IDLE;
         endcase
      end

   assign buf_out_addr      = buf_out_addr_q;
   assign buf_out_arm       = buf_out_arm_q;
   assign usb_in_addr       = usb_in_addr_q;
   assign usb_in_data       = usb_in_data_q;
   assign usb_in_wren       = usb_in_wren_q;
   assign usb_in_commit     = usb_in_commit_q;
   assign usb_in_commit_len = commit_len_q;
   assign wb_adr_o          = wb_adr_q;
   assign wb_dat_o          = wb_dat_q;
   assign wb_we_o           = wb_we_q;
   assign wb_stb_o          = wb_stb_q;
   assign reset_ctrl        = reset_ctrl_q;
   assign insel             = insel_q;
   assign isoc_commit_len   = isoc_q;
   assign err_cnt           = err_q;
endmodule

// File: tb/tb_ep2_cmd_decoder.sv
// tb_ep2_cmd_decoder: packet table plus scoreboards for wishbone cycles and IN-buffer writes,
// with modelled OUT-buffer latency, arm handshake and commit responder.
module tb_ep2_cmd_decoder;
   localparam int RD_LAT = 4;
   localparam int WB_TIMEOUT = 1023;

   logic clk = 1'b0, reset_n = 1'b0;
   logic buf_out_hasdata = 1'b0, buf_out_arm_ack = 1'b0, usb_in_ready = 1'b1;
   logic usb_in_commit_ack = 1'b0, wb_ack_i = 1'b0;
   logic [9:0] buf_out_len = '0;
   logic [7:0] buf_out_q = '0, wb_dat_i = '0;
   logic [8:0] buf_out_addr, usb_in_addr;
   logic [7:0] usb_in_data, wb_dat_o, reset_ctrl, err_cnt;
   logic buf_out_arm, usb_in_wren, usb_in_commit, wb_we_o, wb_stb_o;
   logic [9:0] usb_in_commit_len;
   logic [2:0] wb_adr_o;
   logic [1:0] insel;
   logic [10:0] isoc_commit_len;

   always #10 clk = ~clk;

   ep2_cmd_decoder #(.RD_LAT(RD_LAT), .WB_TIMEOUT(WB_TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n),
      .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len),
      .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q),
      .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
      .usb_in_addr(usb_in_addr), .usb_in_data(usb_in_data), .usb_in_wren(usb_in_wren),
      .usb_in_ready(usb_in_ready), .usb_in_commit(usb_in_commit),
      .usb_in_commit_len(usb_in_commit_len), .usb_in_commit_ack(usb_in_commit_ack),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .reset_ctrl(reset_ctrl), .insel(insel), .isoc_commit_len(isoc_commit_len),
      .err_cnt(err_cnt)
   );

   typedef struct {
      int n; logic [0:7][7:0] b; int dly; logic [7:0] rd0, rd1;
      logic [7:0] rc; logic [1:0] ins; logic [10:0] isoc; logic [7:0] err;
      int ncommit; logic [9:0] clen; int stb;
   } vec_t;

   logic [7:0] mem [512];
   logic [7:0] pipe [RD_LAT];
   logic [11:0] exp_wb [$];
   logic [16:0] exp_in [$];
   logic [7:0] rdq [$];
   int errors = 0, checks = 0;
   int ack_dly = 0, stb_cnt = 0, stb_max = 0, arm_pulses = 0, ack_hold = 0, commits = 0;
   logic arm_prev = 1'b0, commit_prev = 1'b0;
   logic [9:0] clen = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one bench cycle: all sampling and responder driving happens on the falling edge
   task automatic tick();
      logic [11:0] e;
      logic [16:0] ei;
      @(negedge clk);
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = mem[buf_out_addr];
      buf_out_q = pipe[RD_LAT-1];
      if (wb_stb_o) begin
         stb_cnt++;
         if (stb_cnt == 1) begin
            if (exp_wb.size() == 0) chk("wb_unexpected_cycle", 32'(wb_adr_o), 32'hFFFF);
            else begin
               e = exp_wb.pop_front();
               chk("wb_adr", 32'(wb_adr_o), 32'(e[11:9]));
               chk("wb_we", 32'(wb_we_o), 32'(e[0]));
               if (e[0]) chk("wb_dat", 32'(wb_dat_o), 32'(e[8:1]));
            end
         end
         if (stb_cnt > stb_max) stb_max = stb_cnt;
         if (ack_dly != 0 && stb_cnt == ack_dly) begin
            wb_ack_i = 1'b1;
            wb_dat_i = 8'h00;
            if (!wb_we_o && rdq.size() > 0) wb_dat_i = rdq.pop_front();
         end else
            wb_ack_i = 1'b0;
      end else begin
         stb_cnt = 0;
         wb_ack_i = 1'b0;
      end
      if (usb_in_wren) begin
         if (exp_in.size() == 0) chk("in_unexpected_write", 32'(usb_in_data), 32'hFFFF);
         else begin
            ei = exp_in.pop_front();
            chk("in_addr", 32'(usb_in_addr), 32'(ei[16:8]));
            chk("in_data", 32'(usb_in_data), 32'(ei[7:0]));
         end
      end
      if (buf_out_arm && !arm_prev) begin
         arm_pulses++;
         buf_out_hasdata = 1'b0;
         buf_out_arm_ack = 1'b1;
         ack_hold = 3;
      end else if (ack_hold > 0) begin
         ack_hold--;
         if (ack_hold == 0) buf_out_arm_ack = 1'b0;
      end
      arm_prev = buf_out_arm;
      if (usb_in_commit) begin
         if (!commit_prev) begin
            commits++;
            clen = usb_in_commit_len;
         end
         usb_in_commit_ack = 1'b1;
      end else
         usb_in_commit_ack = 1'b0;
      commit_prev = usb_in_commit;
   endtask

   task automatic run_pkt(input int len, input int dly, input int budget);
      int post = 0;
      ack_dly = dly; stb_max = 0; arm_pulses = 0; commits = 0; clen = '0;
      buf_out_len = 10'(len);
      buf_out_hasdata = 1'b1;
      for (int c = 0; c < budget && post < 20; c++) begin
         tick();
         if (arm_pulses > 0 && !buf_out_arm && !buf_out_arm_ack) post++;
      end
      if (post < 20) begin
         checks++; errors++;
         $display("FAIL pkt_done: packet len %0d not released within %0d cycles", len, budget);
         buf_out_hasdata = 1'b0;
      end
      chk("wb_queue_drained", 32'(exp_wb.size()), 0);
      chk("in_queue_drained", 32'(exp_in.size()), 0);
      exp_wb.delete(); exp_in.delete(); rdq.delete();
   endtask

   // expected wishbone cycles and IN bytes follow directly from the pair list
   task automatic load_vec(input vec_t v);
      int nrd = 0;
      logic [7:0] a, d, r;
      for (int i = 0; i < 8; i++) mem[i] = v.b[i];
      for (int p = 0; p < v.n / 2; p++) begin
         a = v.b[2*p]; d = v.b[2*p+1];
         if (a <= 8'd4) exp_wb.push_back({a[2:0], d, 1'b1});
         else if (a == 8'd5) begin
            exp_wb.push_back({d[2:0], 8'h00, 1'b0});
            if (v.dly != 0) begin
               r = (nrd == 0) ? v.rd0 : v.rd1;
               rdq.push_back(r);
               exp_in.push_back({9'(nrd), r});
               nrd++;
            end
         end
      end
   endtask

   vec_t vecs [8];

   initial begin
      vecs[0] = '{n:2, b:'{8'h06,8'hA5,0,0,0,0,0,0}, dly:5, rd0:0, rd1:0, rc:8'hA5, ins:0,
                  isoc:11'h200, err:0, ncommit:0, clen:0, stb:0};
      vecs[1] = '{n:6, b:'{8'h07,8'h02,8'h08,8'h03,8'h09,8'hFF,0,0}, dly:5, rd0:0, rd1:0,
                  rc:8'hA5, ins:2, isoc:11'h3FF, err:0, ncommit:0, clen:0, stb:0};
      vecs[2] = '{n:2, b:'{8'h03,8'h55,0,0,0,0,0,0}, dly:5, rd0:0, rd1:0, rc:8'hA5, ins:2,
                  isoc:11'h3FF, err:0, ncommit:0, clen:0, stb:5};
      vecs[3] = '{n:4, b:'{8'h05,8'h04,8'h05,8'h03,0,0,0,0}, dly:2, rd0:8'h81, rd1:8'h3C,
                  rc:8'hA5, ins:2, isoc:11'h3FF, err:0, ncommit:1, clen:10'd2, stb:2};
      vecs[4] = '{n:5, b:'{8'h0C,8'h11,8'h02,8'h7E,8'h00,0,0,0}, dly:0, rd0:0, rd1:0,
                  rc:8'hA5, ins:2, isoc:11'h3FF, err:2, ncommit:0, clen:0, stb:WB_TIMEOUT};
      vecs[5] = '{n:1, b:'{8'h06,8'h00,0,0,0,0,0,0}, dly:5, rd0:0, rd1:0, rc:8'hA5, ins:2,
                  isoc:11'h3FF, err:2, ncommit:0, clen:0, stb:0};
      vecs[6] = '{n:0, b:'{0,0,0,0,0,0,0,0}, dly:5, rd0:0, rd1:0, rc:8'hA5, ins:2,
                  isoc:11'h3FF, err:2, ncommit:0, clen:0, stb:0};
      vecs[7] = '{n:4, b:'{8'h06,8'h3C,8'h07,8'h01,0,0,0,0}, dly:5, rd0:0, rd1:0, rc:8'h3C,
                  ins:1, isoc:11'h3FF, err:2, ncommit:0, clen:0, stb:0};
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      for (int i = 0; i < RD_LAT; i++) pipe[i] = 8'h00;

      repeat (3) tick();
      chk("rst_buf_out_addr", 32'(buf_out_addr), 0);
      chk("rst_arm", 32'(buf_out_arm), 0);
      chk("rst_in_addr", 32'(usb_in_addr), 0);
      chk("rst_wren", 32'(usb_in_wren), 0);
      chk("rst_commit", 32'(usb_in_commit), 0);
      chk("rst_stb", 32'(wb_stb_o), 0);
      chk("rst_wb_adr", 32'(wb_adr_o), 0);
      chk("rst_reset_ctrl", 32'(reset_ctrl), 32'hF3);
      chk("rst_insel", 32'(insel), 0);
      chk("rst_isoc_len", 32'(isoc_commit_len), 512);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      reset_n = 1'b1;
      repeat (3) tick();

      for (int v = 0; v < 8; v++) begin
         load_vec(vecs[v]);
         run_pkt(vecs[v].n, vecs[v].dly, 5000);
         chk($sformatf("v%0d_reset_ctrl", v), 32'(reset_ctrl), 32'(vecs[v].rc));
         chk($sformatf("v%0d_insel", v), 32'(insel), 32'(vecs[v].ins));
         chk($sformatf("v%0d_isoc_len", v), 32'(isoc_commit_len), 32'(vecs[v].isoc));
         chk($sformatf("v%0d_err_cnt", v), 32'(err_cnt), 32'(vecs[v].err));
         chk($sformatf("v%0d_arm_pulses", v), 32'(arm_pulses), 1);
         chk($sformatf("v%0d_commits", v), 32'(commits), 32'(vecs[v].ncommit));
         if (vecs[v].ncommit > 0) chk($sformatf("v%0d_commit_len", v), 32'(clen), 32'(vecs[v].clen));
         if (vecs[v].stb > 0) chk($sformatf("v%0d_stb_cycles", v), 32'(stb_max), 32'(vecs[v].stb));
      end

      // 255 undefined-address pairs push err_cnt past its ceiling
      for (int i = 0; i < 510; i++) mem[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
      run_pkt(510, 5, 8000);
      chk("sat_err_cnt", 32'(err_cnt), 255);
      chk("sat_reset_ctrl", 32'(reset_ctrl), 32'h3C);

      // asynchronous reset while a wishbone write is stalled
      mem[0] = 8'h01; mem[1] = 8'h99;
      exp_wb.push_back({3'd1, 8'h99, 1'b1});
      ack_dly = 0; arm_pulses = 0;
      buf_out_len = 10'd2;
      buf_out_hasdata = 1'b1;
      for (int c = 0; c < 100 && !wb_stb_o; c++) tick();
      chk("mid_stb_raised", 32'(wb_stb_o), 1);
      repeat (3) tick();
      reset_n = 1'b0;
      buf_out_hasdata = 1'b0;
      #1;
      chk("mid_rst_stb", 32'(wb_stb_o), 0);
      chk("mid_rst_reset_ctrl", 32'(reset_ctrl), 32'hF3);
      chk("mid_rst_insel", 32'(insel), 0);
      chk("mid_rst_isoc_len", 32'(isoc_commit_len), 512);
      chk("mid_rst_err_cnt", 32'(err_cnt), 0);
      repeat (5) tick();
      reset_n = 1'b1;
      repeat (20) tick();
      chk("mid_rst_no_arm", 32'(arm_pulses), 0);
      chk("mid_rst_idle_stb", 32'(wb_stb_o), 0);
      chk("mid_rst_wb_drained", 32'(exp_wb.size()), 0);
      exp_wb.delete();

      mem[0] = 8'h06; mem[1] = 8'h11;
      run_pkt(2, 5, 5000);
      chk("post_rst_reset_ctrl", 32'(reset_ctrl), 32'h11);
      chk("post_rst_arm_pulses", 32'(arm_pulses), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
